// File: rtl/zxdos_btn_reset_ctrl_pkg.sv
// Shared types and default timing for the ZXDOS front-panel button / reset sequencer.
package zxdos_btn_pkg;

  typedef enum logic [2:0] {
    ST_POR,
    ST_IDLE,
    ST_PRESS,
    ST_HOLD,
    ST_PULSE
  } seq_state_t;

  localparam int DEB_CYCLES_DEF  = 500000;
  localparam int LONG_CYCLES_DEF = 100000000;
  localparam int RST_PULSE_DEF   = 1024;

endpackage

// File: rtl/zxdos_btn_reset_ctrl_debounce.sv
// One button: 2-flop synchroniser, stability counter, and press/release strobes.
module btn_debounce
  import zxdos_btn_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_stb,
  output logic release_stb
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          lvl;
  logic          deb;
  logic [CW-1:0] cnt;

  // Inverted after synchronisation so that pressed = 1
  assign lvl = ~sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= 2'b11;
      deb         <= 1'b0;
      cnt         <= '0;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
    end else begin
      sync        <= {sync[0], btn_n};
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
      if (lvl == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt         <= '0;
        deb         <= lvl;
        press_stb   <= lvl;
        release_stb <= ~lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/zxdos_btn_reset_ctrl.sv
// Button conditioner and reset sequencer feeding BTN_RESET / BTN_NMI into system.
module zxdos_btn_reset_ctrl
  import zxdos_btn_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int RST_PULSE   = RST_PULSE_DEF
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic [1:0] BTN,
  input  logic       calib_done,
  output logic       BTN_RESET,
  output logic       BTN_NMI,
  output logic       COLD_BOOT,
  output logic [1:0] LED_int
);
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);

  seq_state_t    state, next_state;
  logic [1:0]    calib_sync;
  logic          calib_ok;
  logic [1:0]    press;
  logic          rst_release;
  logic          nmi_release_unused;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] pulse_cnt;
  logic          busy;
  logic          btn_reset_d, btn_nmi_d, cold_boot_d, busy_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .clk        (CLK_50MHZ),
    .rst        (RST),
    .btn_n      (BTN[0]),
    .press_stb  (press[0]),
    .release_stb(rst_release)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_nmi (
    .clk        (CLK_50MHZ),
    .rst        (RST),
    .btn_n      (BTN[1]),
    .press_stb  (press[1]),
    .release_stb(nmi_release_unused)
  );

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) calib_sync <= 2'b00;
    else     calib_sync <= {calib_sync[0], calib_done};
  end
  assign calib_ok = calib_sync[1];

  // State register; outputs are registered from the next-state decode
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state     <= ST_POR;
      BTN_RESET <= 1'b1;
      BTN_NMI   <= 1'b0;
      COLD_BOOT <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      BTN_RESET <= btn_reset_d;
      BTN_NMI   <= btn_nmi_d;
      COLD_BOOT <= cold_boot_d;
      busy      <= busy_d;
    end
  end

  // Release beats reaching the long-press threshold so a release is never lost
  always_comb begin
    next_state = state;
    unique case (state)
      ST_POR:   if (calib_ok) next_state = ST_PULSE;
      ST_IDLE:  if (press[0]) next_state = ST_PRESS;
      ST_PRESS: begin
        if (rst_release)                next_state = ST_PULSE;
        else if (hold_cnt == HOLD_LAST) next_state = ST_HOLD;
      end
      ST_HOLD:  if (rst_release) next_state = ST_PULSE;
      ST_PULSE: if (pulse_cnt == PULSE_LAST) next_state = ST_IDLE;
      default:  next_state = ST_POR;
    endcase
    if (!calib_ok) next_state = ST_POR;
  end

  always_comb begin
    btn_reset_d = (next_state != ST_IDLE);
    btn_nmi_d   = (state == ST_IDLE) && (next_state == ST_IDLE) && press[1];
    cold_boot_d = (next_state == ST_POR) || (next_state == ST_HOLD) ||
                  (COLD_BOOT && (next_state != ST_IDLE));
    busy_d      = next_state inside {ST_PRESS, ST_HOLD, ST_PULSE};
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      hold_cnt  <= '0;
      pulse_cnt <= '0;
    end else begin
      if (next_state == ST_PRESS && state != ST_PRESS)      hold_cnt <= '0;
      else if (next_state == ST_PRESS && state == ST_PRESS) hold_cnt <= hold_cnt + 1'b1;
      if (next_state == ST_PULSE && state != ST_PULSE)      pulse_cnt <= '0;
      else if (next_state == ST_PULSE && state == ST_PULSE) pulse_cnt <= pulse_cnt + 1'b1;
    end
  end

  assign LED_int = {calib_ok, busy};

endmodule

// File: tb/tb_zxdos_btn_reset_ctrl.sv
// Bench for zxdos_btn_reset_ctrl: directed scenarios plus random button/calibration traffic.
module tb_zxdos_btn_reset_ctrl;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int PULSE = 8;
  localparam int M_POR = 0, M_IDLE = 1, M_PRESS = 2, M_HOLD = 3, M_PULSE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn = 2'b11;
  logic       calib = 1'b0;
  logic       btn_reset, btn_nmi, cold_boot;
  logic [1:0] led;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  zxdos_btn_reset_ctrl #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .RST_PULSE(PULSE)) dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .BTN       (btn),
    .calib_done(calib),
    .BTN_RESET (btn_reset),
    .BTN_NMI   (btn_nmi),
    .COLD_BOOT (cold_boot),
    .LED_int   (led)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: window-based debouncing and time-stamped sequencer modes
  int         m_mode = M_POR, m_cyc = 0, t_press = 0, t_pulse = 0;
  bit         m_cold = 1, m_nmi = 0, m_busy = 0, m_rst_o = 1;
  bit [1:0]   m_p1 = 0, m_p2 = 0, m_deb = 0, m_pr = 0, m_rl = 0;
  bit [DEB-1:0] m_win [2];
  bit         m_c1 = 0, m_c2 = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_POR; m_cold = 1; m_nmi = 0; m_busy = 0; m_rst_o = 1;
      m_p1 = 0; m_p2 = 0; m_deb = 0; m_pr = 0; m_rl = 0;
      m_win[0] = '0; m_win[1] = '0; m_c1 = 0; m_c2 = 0; m_cyc = 0;
    end else begin
      bit cal_seen;
      m_cyc++;
      cal_seen = m_c2;
      m_nmi = 0;
      if (!cal_seen) begin
        m_mode = M_POR; m_cold = 1;
      end else begin
        case (m_mode)
          M_POR:   begin m_mode = M_PULSE; t_pulse = m_cyc; end
          M_IDLE:  if (m_pr[0]) begin m_mode = M_PRESS; t_press = m_cyc; end
                   else if (m_pr[1]) m_nmi = 1;
          M_PRESS: if (m_rl[0]) begin m_mode = M_PULSE; t_pulse = m_cyc; end
                   else if (m_cyc - t_press == LONG) begin m_mode = M_HOLD; m_cold = 1; end
          M_HOLD:  if (m_rl[0]) begin m_mode = M_PULSE; t_pulse = m_cyc; end
          M_PULSE: if (m_cyc - t_pulse == PULSE) begin m_mode = M_IDLE; m_cold = 0; end
          default: m_mode = M_POR;
        endcase
      end
      m_rst_o = (m_mode != M_IDLE);
      m_busy  = (m_mode == M_PRESS) || (m_mode == M_HOLD) || (m_mode == M_PULSE);
      for (int b = 0; b < 2; b++) begin
        bit lv;
        lv = m_p2[b]; m_p2[b] = m_p1[b]; m_p1[b] = !btn[b];
        m_win[b] = {m_win[b][DEB-2:0], lv};
        m_pr[b] = 0; m_rl[b] = 0;
        if (m_win[b] == '1 && !m_deb[b])      begin m_deb[b] = 1; m_pr[b] = 1; end
        else if (m_win[b] == '0 && m_deb[b])  begin m_deb[b] = 0; m_rl[b] = 1; end
      end
      m_c2 = m_c1; m_c1 = calib;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("model_btn_reset", btn_reset, m_rst_o);
      check_val("model_btn_nmi", btn_nmi, m_nmi);
      check_val("model_cold_boot", cold_boot, m_cold);
      check_val("model_led", led, {m_c2, m_busy});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!btn_reset) break;
    end
    check_val(tag, btn_reset, 0);
  endtask

  initial begin
    int n, hi, pulses, at, seen;
    int rem0, rem1, remc;

    // Power-on
    rst = 1; cycles(3);
    check_val("rst_btn_reset", btn_reset, 1);
    check_val("rst_cold_boot", cold_boot, 1);
    check_val("rst_btn_nmi", btn_nmi, 0);
    check_val("rst_led", led, 2'b00);
    chk_en = 1;
    rst = 0; cycles(7);
    calib = 1;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!btn_reset) break;
      hi++;
    end
    check_val("por_high_cycles", hi, 2 + PULSE);
    check_val("por_cold_fall", cold_boot, 0);

    // Bounce rejection, then a clean press
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      btn[0] = (i % 3 == 2);
      @(negedge clk);
      seen |= btn_reset;
    end
    check_val("bounce_no_reset", seen, 0);
    btn[0] = 0; n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (btn_reset) begin n = i; break; end
    end
    check_val("press_latency", n, 2 + DEB + 1);
    cycles(3);
    check_val("short_cold", cold_boot, 0);
    btn[0] = 1;
    wait_idle("idle_after_short");

    // Long press
    btn[0] = 0; n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (btn_reset) begin n = i; break; end
    end
    at = 0;
    for (int j = 1; j <= 50; j++) begin
      @(negedge clk);
      if (cold_boot) begin at = j; break; end
    end
    check_val("long_cold_delay", at, LONG);
    cycles(40 - n - at);
    btn[0] = 1; hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!btn_reset) break;
      hi++;
    end
    check_val("long_release_high", hi, 2 + DEB + PULSE);
    check_val("long_cold_fall", cold_boot, 0);

    // NMI in IDLE
    btn[1] = 0; pulses = 0; at = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (btn_nmi) begin pulses++; at = i; end
    end
    check_val("nmi_pulses", pulses, 1);
    check_val("nmi_latency", at, 2 + DEB + 1);
    btn[1] = 1; cycles(10);

    // NMI arriving during PULSE is dropped
    btn[0] = 0; cycles(6);
    btn[0] = 1; cycles(2);
    btn[1] = 0; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (btn_nmi) pulses++;
    end
    check_val("nmi_in_pulse", pulses, 0);
    btn[1] = 1; cycles(10);

    // Simultaneous presses
    btn = 2'b00; seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= btn_nmi;
    end
    check_val("simul_reset", btn_reset, 1);
    check_val("simul_nmi", seen, 0);
    btn = 2'b11;
    wait_idle("idle_after_simul");
    cycles(10);

    // Calibration loss during PRESS
    btn[0] = 0; cycles(10);
    calib = 0; cycles(3);
    check_val("calib_loss_cold", cold_boot, 1);
    check_val("calib_loss_led1", led[1], 0);
    check_val("calib_loss_reset", btn_reset, 1);
    btn[0] = 1; cycles(10);
    calib = 1;
    wait_idle("idle_after_calib");
    check_val("calib_back_cold", cold_boot, 0);

    // Random traffic against the model
    rem0 = $urandom_range(1, 40); rem1 = $urandom_range(1, 12); remc = 300;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rem0 == 0) begin btn[0] = ~btn[0]; rem0 = $urandom_range(1, 45); end else rem0--;
      if (rem1 == 0) begin btn[1] = ~btn[1]; rem1 = $urandom_range(1, 12); end else rem1--;
      if (remc == 0) begin
        calib = ~calib;
        remc = calib ? $urandom_range(100, 600) : $urandom_range(1, 8);
      end else remc--;
      rst = ($urandom_range(0, 1499) == 0);
    end
    rst = 0;
    cycles(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
